load_store_unit: RTL and testbench
==================================

# load_store_unit

Bridges the single-cycle core's data-memory port to a request/acknowledge data bus. It sits directly downstream of the core datapath: it takes the ALU result as the address, register rs2 as store data, and the access size. It drives word-aligned bus transfers with byte enables, splits misaligned accesses into two transfers, and stalls the core until the access completes. It returns load data right-justified to the datapath's read-data extension logic.

## Interface
- No parameters; address and data widths fixed at 32.
- i_clk  in  1  single clock, all state on rising edge
- i_reset_x  in  1  asynchronous, active-low reset
- i_memRead  in  1  load request for current instruction
- i_memWrite  in  1  store request for current instruction
- i_memSize  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- i_addr  in  32  byte address (ALU output)
- i_wdata  in  32  store data, right-justified (rs2)
- o_stall  out  1  core must hold PC and register write this cycle
- o_rdata  out  32  load data right-justified, unused upper bits zero
- o_busReq  out  1  bus transfer request
- o_busWe  out  1  1 = write transfer
- o_busAddr  out  32  word-aligned address, bits [1:0] always 0
- o_busBe  out  4  byte enables, bit n = byte lane n
- o_busWdata  out  32  lane-aligned write data
- i_busAck  in  1  transfer completes in a cycle where o_busReq & i_busAck
- i_busRdata  in  32  read data, valid in the ack cycle

## Operation
- FSM states: IDLE, ACC0, ACC1, DONE.
- IDLE: when i_memRead | i_memWrite, latch addr, wdata, size and we = i_memWrite, then go to ACC0. If both request bits are set, the access is a write. Without a request, stay in IDLE.
- ACC0: o_busReq = 1; addr = {a[31:2],2'b00}.
  - On ack, capture i_busRdata into low word.
  - Go to ACC1 if the access crosses a word boundary, else go to DONE.
- ACC1: o_busReq = 1; addr = first address + 4. On ack, capture i_busRdata into high word, then go to DONE.
- DONE: o_stall = 0, o_rdata valid; core retires the instruction at the end of this cycle. Then go to IDLE unconditionally.
- Let off = a[1:0] and mask = 0001/0011/1111 for byte/half/word.
- Word-boundary crossing: half with off = 3, or word with off != 0. Byte accesses never cross.
- Byte enables and write data per transfer:
  - ACC0: be = (mask << off)[3:0]; wdata = wd << 8*off.
  - ACC1: be = (mask << off)[7:4]; wdata = wd >> 8*(4-off).
- Load assembly: o_rdata = ({hi, lo} >> 8*off) masked to size. hi = 0 when there is no ACC1.
- o_stall = (IDLE & (i_memRead | i_memWrite)) | ACC0 | ACC1. This is combinational from the request inputs.
- i_busAck is ignored in IDLE and DONE.
- Core inputs are ignored outside IDLE; latched values are used.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - o_busReq, o_busWe, o_busAddr, o_busBe, o_busWdata and o_rdata go to 0.
  - o_stall follows its equation (0 with no request).
- Reset mid-transfer abandons the access, and no retry follows. Byte lanes already written by an acknowledged ACC0 stay written.
- Bus outputs are registered and held stable while o_busReq = 1 and ack is absent. Wait states are unlimited.
- ACC0 to ACC1 transition: o_busReq stays 1; address, be and wdata update on the edge after the ACC0 ack.
- o_busReq = 0 in IDLE and DONE.
- Aligned access, zero-wait bus: request cycle (IDLE), ACC0 with ack, then DONE. That is 3 cycles, with o_stall high for the first 2.
- Split access, zero-wait bus: 4 cycles.
- Each bus wait state adds 1 cycle.
- o_rdata updates on the edge entering DONE and holds until the next capture. For stores, its value is don't-care.

## Test plan
- Aligned word load: addr 0x100, size 10; bus acks in the first cycle with 0xDEADBEEF. Required: one transfer with be 1111 and addr 0x100; o_rdata = 0xDEADBEEF in DONE; o_stall high for exactly 2 cycles.
- Byte store: addr 0x203, wd 0x000000A5, size 00. Required: addr 0x200, be 1000, wdata 0xA5000000, we 1; a single transfer.
- Misaligned word load: addr 0x102; rdata 0x11223344 at 0x100 and 0x55667788 at 0x104. Required: two transfers with be 1100 then 0011; o_rdata = 0x77881122.
- Misaligned half store: addr 0x0FF, wd 0xBEEF. Required: transfer 1 at 0x0FC with be 1000 and wdata 0xEF000000; transfer 2 at 0x100 with be 0001 and wdata 0x000000BE.
- Wait states: word load with ack delayed 3 cycles. Required: o_busReq, o_busAddr and o_busBe constant throughout; o_stall high for 5 cycles; ack in IDLE has no effect.
- Reset mid-ACC1: assert i_reset_x low during ACC1. Required: o_busReq drops immediately and all outputs read 0. After release with no request, state stays IDLE and o_stall = 0.

Source files
------------

// File: rtl/load_store_unit.sv
// Bridges the core's single-cycle data-memory port to a req/ack word bus, splitting
// misaligned loads/stores into two word transfers and stalling the core until done.
module load_store_unit (
    input  logic        i_clk,
    input  logic        i_reset_x,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_memSize,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_busReq,
    output logic        o_busWe,
    output logic [31:0] o_busAddr,
    output logic [3:0]  o_busBe,
    output logic [31:0] o_busWdata,
    input  logic        i_busAck,
    input  logic [31:0] i_busRdata
);

    // Bus handshake: a transfer completes on a rising edge where o_busReq and i_busAck
    // are both high; all bus outputs hold steady while o_busReq waits for an ack.
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic [31:0] r_lo;
    logic [31:0] r_rdata;
    logic        r_busReq;
    logic        r_busWe;
    logic [31:0] r_busAddr;
    logic [3:0]  r_busBe;
    logic [31:0] r_busWdata;

    function automatic logic [3:0] f_mask(input logic [1:0] size);
        case (size)
            2'b00:   f_mask = 4'b0001;
            2'b01:   f_mask = 4'b0011;
            default: f_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_dmask(input logic [1:0] size);
        logic [3:0] m;
        m = f_mask(size);
        f_dmask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic f_cross(input logic [1:0] size, input logic [1:0] off);
        f_cross = ((size == 2'b01) && (off == 2'b11)) || (size[1] && (off != 2'b00));
    endfunction

    logic        w_req;
    logic [3:0]  w_in_be0;
    logic [31:0] w_in_wd0;
    logic [3:0]  w_lt_be1;
    logic [5:0]  w_rsh;
    logic [31:0] w_lt_wd1;
    logic        w_cross;
    logic [31:0] w_lo_data;
    logic [31:0] w_hi_data;
    logic [31:0] w_load;

    assign w_req    = i_memRead | i_memWrite;
    assign w_in_be0 = 4'({4'b0000, f_mask(i_memSize)} << i_addr[1:0]);
    assign w_in_wd0 = i_wdata << {i_addr[1:0], 3'b000};
    assign w_lt_be1 = 4'(({4'b0000, f_mask(r_size)} << r_addr[1:0]) >> 4);
    assign w_rsh    = 6'd32 - {1'b0, r_addr[1:0], 3'b000};
    assign w_lt_wd1 = r_wdata >> w_rsh;
    assign w_cross  = f_cross(r_size, r_addr[1:0]);

    // Load data is assembled straight from the ack cycle's bus data so o_rdata is
    // ready on the edge that enters DONE.
    assign w_lo_data = (r_state == ACC0) ? i_busRdata : r_lo;
    assign w_hi_data = (r_state == ACC1) ? i_busRdata : 32'h0;
    assign w_load    = 32'({w_hi_data, w_lo_data} >> {r_addr[1:0], 3'b000}) & f_dmask(r_size);

    always_ff @(posedge i_clk or negedge i_reset_x) begin
        if (!i_reset_x) begin
            r_state    <= IDLE;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_size     <= 2'b00;
            r_lo       <= 32'h0;
            r_rdata    <= 32'h0;
            r_busReq   <= 1'b0;
            r_busWe    <= 1'b0;
            r_busAddr  <= 32'h0;
            r_busBe    <= 4'h0;
            r_busWdata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr     <= i_addr;
                        r_wdata    <= i_wdata;
                        r_size     <= i_memSize;
                        r_busReq   <= 1'b1;
                        r_busWe    <= i_memWrite;
                        r_busAddr  <= {i_addr[31:2], 2'b00};
                        r_busBe    <= w_in_be0;
                        r_busWdata <= w_in_wd0;
                        r_state    <= ACC0;
                    end
                end
                ACC0: begin
                    if (i_busAck) begin
                        r_lo <= i_busRdata;
                        if (w_cross) begin
                            r_busAddr  <= {r_addr[31:2], 2'b00} + 32'd4;
                            r_busBe    <= w_lt_be1;
                            r_busWdata <= w_lt_wd1;
                            r_state    <= ACC1;
                        end else begin
                            r_busReq <= 1'b0;
                            r_busWe  <= 1'b0;
                            r_busBe  <= 4'h0;
                            r_rdata  <= w_load;
                            r_state  <= DONE;
                        end
                    end
                end
                ACC1: begin
                    if (i_busAck) begin
                        r_busReq <= 1'b0;
                        r_busWe  <= 1'b0;
                        r_busBe  <= 4'h0;
                        r_rdata  <= w_load;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_stall    = ((r_state == IDLE) && w_req) || (r_state == ACC0) || (r_state == ACC1);
    assign o_rdata    = r_rdata;
    assign o_busReq   = r_busReq;
    assign o_busWe    = r_busWe;
    assign o_busAddr  = r_busAddr;
    assign o_busBe    = r_busBe;
    assign o_busWdata = r_busWdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed memory model behind a bus responder,
// expected transfers derived byte by byte, checked every cycle at the falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_memRead, i_memWrite;
  logic [1:0]  i_memSize;
  logic [31:0] i_addr, i_wdata;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_busReq, o_busWe;
  logic [31:0] o_busAddr;
  logic [3:0]  o_busBe;
  logic [31:0] o_busWdata;
  logic        i_busAck;
  logic [31:0] i_busRdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_clk(clk), .i_reset_x(rst_n),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_memSize(i_memSize),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_rdata(o_rdata),
    .o_busReq(o_busReq), .o_busWe(o_busWe), .o_busAddr(o_busAddr),
    .o_busBe(o_busBe), .o_busWdata(o_busWdata),
    .i_busAck(i_busAck), .i_busRdata(i_busRdata)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // byte-addressed memory model
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rd_byte(a + i);
    return w;
  endfunction

  task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + i] = w[8*i +: 8];
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // transfer record {we[68], addr[67:36], be[35:32], wdata[31:0]}
  logic [68:0] exp_q[$];
  logic [68:0] obs_q[$];

  bit          active = 0;
  bit          exp_load;
  int          exp_stall;
  logic [31:0] exp_rdata;
  int          stall_cnt;
  logic [31:0] done_rdata;
  int          done_stall;
  int          wait_n = 0;
  int          w_cnt = 0;
  bit          stray_ack = 0;
  logic        prev_req = 0, prev_ack = 0, prev_we;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_be;

  // compare process + bus responder, evaluated mid-cycle
  always @(negedge clk) begin
    logic [68:0] e;
    logic        hs;
    if (!rst_n) begin
      i_busAck = 1'b0;
      w_cnt    = 0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_req && !prev_ack && o_busReq) begin
        check("hold_addr", o_busAddr, prev_addr);
        check("hold_be", {28'h0, o_busBe}, {28'h0, prev_be});
        check("hold_wdata", o_busWdata, prev_wdata);
        check("hold_we", {31'h0, o_busWe}, {31'h0, prev_we});
      end
      if (o_busReq) begin
        check("addr_align", {30'h0, o_busAddr[1:0]}, 32'h0);
        check("req_implies_stall", {31'h0, o_stall}, 32'h1);
      end
      hs = o_busReq && (w_cnt >= wait_n);
      if (hs) begin
        i_busAck   = 1'b1;
        i_busRdata = rd_word(o_busAddr);
        w_cnt      = 0;
        obs_q.push_back({o_busWe, o_busAddr, o_busBe, o_busWdata});
        if (exp_q.size() == 0) begin
          chk_cnt++;
          err_cnt++;
          $display("FAIL xfer_extra: got addr %h be %b, expected no transfer", o_busAddr, o_busBe);
        end else begin
          e = exp_q.pop_front();
          check("xfer_we", {31'h0, o_busWe}, {31'h0, e[68]});
          check("xfer_addr", o_busAddr, e[67:36]);
          check("xfer_be", {28'h0, o_busBe}, {28'h0, e[35:32]});
          if (e[68]) check("xfer_wdata", o_busWdata & lane_mask(o_busBe), e[31:0]);
        end
        if (o_busWe)
          for (int i = 0; i < 4; i++)
            if (o_busBe[i]) mem[o_busAddr + i] = o_busWdata[8*i +: 8];
      end else begin
        i_busAck   = stray_ack;
        i_busRdata = $urandom;
        if (o_busReq) w_cnt++;
      end
      prev_req = o_busReq; prev_ack = hs; prev_we = o_busWe;
      prev_addr = o_busAddr; prev_be = o_busBe; prev_wdata = o_busWdata;
      if (active) begin
        if (o_stall) stall_cnt++;
        else begin
          check("stall_cycles", stall_cnt, exp_stall);
          if (exp_load) check("rdata", o_rdata, exp_rdata);
          check("xfers_left", exp_q.size(), 32'h0);
          done_rdata = o_rdata;
          done_stall = stall_cnt;
          active     = 0;
        end
      end
    end
  end

  // builds the expected transfers from the individual bytes the access touches
  task automatic start_access(input logic rd, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wd, input int waits);
    int n, nx;
    logic [31:0] ba, wa0;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1;
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    wa0 = {addr[31:2], 2'b00};
    be0 = 4'h0; be1 = 4'h0; wd0 = 32'h0; wd1 = 32'h0;
    exp_rdata = 32'h0;
    for (int i = 0; i < n; i++) begin
      ba = addr + i;
      if ({ba[31:2], 2'b00} == wa0) begin
        be0[ba[1:0]] = 1'b1;
        wd0[8*ba[1:0] +: 8] = wd[8*i +: 8];
      end else begin
        be1[ba[1:0]] = 1'b1;
        wd1[8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
      exp_rdata[8*i +: 8] = rd_byte(ba);
    end
    exp_q.push_back({wr, wa0, be0, wd0});
    nx = 1;
    if (be1 != 4'h0) begin
      exp_q.push_back({wr, wa0 + 32'd4, be1, wd1});
      nx = 2;
    end
    exp_stall = 1 + nx * (1 + waits);
    exp_load  = !wr;
    wait_n    = waits;
    obs_q.delete();
    stall_cnt = 0;
    active    = 1;
    i_memRead = rd; i_memWrite = wr; i_memSize = size; i_addr = addr; i_wdata = wd;
  endtask

  // core keeps its request up while stalled; address/data are scrambled to show they are latched
  task automatic finish_access();
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (!active) break;
      i_addr = $urandom; i_wdata = $urandom; i_memSize = 2'($urandom_range(0, 3));
    end
    if (active) begin
      chk_cnt++; err_cnt++;
      $display("FAIL access_timeout: got still stalled after 200 cycles, expected DONE");
      active = 0;
      exp_q.delete();
    end
    i_memRead = 1'b0; i_memWrite = 1'b0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd, input int waits);
    start_access(rd, wr, size, addr, wd, waits);
    finish_access();
  endtask

  function automatic logic [68:0] obs(input int i);
    return (i < obs_q.size()) ? obs_q[i] : 69'h0;
  endfunction

  typedef struct { logic rd; logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wd; } vec_t;
  vec_t vecs[7];

  initial begin
    logic [68:0] t;
    rst_n = 1'b0;
    i_memRead = 1'b0; i_memWrite = 1'b0; i_memSize = 2'b00;
    i_addr = 32'h0; i_wdata = 32'h0; i_busAck = 1'b0; i_busRdata = 32'h0;
    #3;
    check("rst_busReq", {31'h0, o_busReq}, 32'h0);
    check("rst_stall", {31'h0, o_stall}, 32'h0);
    check("rst_busAddr", o_busAddr, 32'h0);
    check("rst_rdata", o_rdata, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #2;

    // aligned word load
    preload_word(32'h100, 32'hDEADBEEF);
    access(1, 0, 2'b10, 32'h100, 32'h0, 0);
    check("t1_rdata", done_rdata, 32'hDEADBEEF);
    check("t1_stall", done_stall, 2);
    check("t1_nxfer", obs_q.size(), 1);
    t = obs(0);
    check("t1_addr", t[67:36], 32'h100);
    check("t1_be", {28'h0, t[35:32]}, 32'hF);

    // byte store to lane 3
    access(0, 1, 2'b00, 32'h203, 32'h000000A5, 0);
    check("t2_nxfer", obs_q.size(), 1);
    t = obs(0);
    check("t2_addr", t[67:36], 32'h200);
    check("t2_be", {28'h0, t[35:32]}, 32'h8);
    check("t2_wdata", t[31:0], 32'hA5000000);
    check("t2_we", {31'h0, t[68]}, 32'h1);

    // misaligned word load
    preload_word(32'h100, 32'h11223344);
    preload_word(32'h104, 32'h55667788);
    access(1, 0, 2'b10, 32'h102, 32'h0, 0);
    check("t3_rdata", done_rdata, 32'h77881122);
    check("t3_stall", done_stall, 3);
    t = obs(0);
    check("t3_be0", {28'h0, t[35:32]}, 32'hC);
    check("t3_addr0", t[67:36], 32'h100);
    t = obs(1);
    check("t3_be1", {28'h0, t[35:32]}, 32'h3);
    check("t3_addr1", t[67:36], 32'h104);

    // misaligned half store
    access(0, 1, 2'b01, 32'h0FF, 32'h0000BEEF, 0);
    t = obs(0);
    check("t4_addr0", t[67:36], 32'h0FC);
    check("t4_be0", {28'h0, t[35:32]}, 32'h8);
    check("t4_wdata0", t[31:0], 32'hEF000000);
    t = obs(1);
    check("t4_addr1", t[67:36], 32'h100);
    check("t4_be1", {28'h0, t[35:32]}, 32'h1);
    check("t4_wdata1", t[31:0], 32'h000000BE);

    // ack while idle must not start anything
    stray_ack = 1;
    repeat (4) begin
      @(posedge clk); #3;
      check("idle_ack_req", {31'h0, o_busReq}, 32'h0);
      check("idle_ack_stall", {31'h0, o_stall}, 32'h0);
    end
    stray_ack = 0;
    @(posedge clk); #2;

    // wait states
    preload_word(32'h300, 32'hCAFEF00D);
    access(1, 0, 2'b10, 32'h300, 32'h0, 3);
    check("t5_stall", done_stall, 5);
    check("t5_rdata", done_rdata, 32'hCAFEF00D);

    // assorted directed vectors with random wait states
    vecs[0] = '{1, 0, 2'b00, 32'h101, 32'h0};
    vecs[1] = '{1, 0, 2'b01, 32'h102, 32'h0};
    vecs[2] = '{0, 1, 2'b01, 32'h105, 32'h00001234};
    vecs[3] = '{0, 1, 2'b10, 32'h10C, 32'h89ABCDEF};
    vecs[4] = '{1, 0, 2'b11, 32'h10B, 32'h0};
    vecs[5] = '{1, 0, 2'b01, 32'h103, 32'h0};
    vecs[6] = '{1, 1, 2'b00, 32'h0FE, 32'h0000005A};
    foreach (vecs[i])
      access(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wd, $urandom_range(0, 2));
    check("t6_mem_0fe", {24'h0, rd_byte(32'h0FE)}, 32'h5A);

    // reset during the second transfer of a split load
    start_access(1, 0, 2'b10, 32'h101, 32'h0, 2);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #2;
      if (obs_q.size() == 1 && o_busReq) break;
    end
    check("t7_in_acc1", {31'h0, o_busReq}, 32'h1);
    i_memRead = 1'b0;
    #1 rst_n = 1'b0;
    active = 0;
    exp_q.delete();
    #1;
    check("t7_busReq", {31'h0, o_busReq}, 32'h0);
    check("t7_busWe", {31'h0, o_busWe}, 32'h0);
    check("t7_busAddr", o_busAddr, 32'h0);
    check("t7_busBe", {28'h0, o_busBe}, 32'h0);
    check("t7_busWdata", o_busWdata, 32'h0);
    check("t7_rdata", o_rdata, 32'h0);
    check("t7_stall", {31'h0, o_stall}, 32'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #3;
      check("t7_post_req", {31'h0, o_busReq}, 32'h0);
      check("t7_post_stall", {31'h0, o_stall}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
